// File: rtl/note_sequencer.sv
// AUTO-mode song sequencer: walks {note, duration} entries from a synchronous ROM,
// plays each note for its tick count, inserts a silent gap, and pulses done at song end.
module note_sequencer #(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned GAP_TICKS = 20,
  parameter int unsigned IDX_W     = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic [1:0]       song_sel_i,
  output logic [IDX_W+1:0] rom_addr_o,
  input  logic [12:0]      rom_data_i,
  output logic [4:0]       note_o,
  output logic             note_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [IDX_W-1:0] idx_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_NEXT,
    S_DONE
  } state_e;

  localparam int unsigned      PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [7:0]       GAP_CNT  = 8'(GAP_TICKS);
  localparam logic [IDX_W-1:0] IDX_LAST = '1;
  localparam logic [4:0]       CODE_END = 5'h1F;

  state_e           state_q, state_d;
  logic [1:0]       song_q, song_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [4:0]       note_q, note_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [7:0]       cnt_q, cnt_d;

  logic       tick;
  logic       run;
  logic [4:0] rom_code;
  logic [7:0] rom_dur;

  assign rom_code = rom_data_i[12:8];
  assign rom_dur  = rom_data_i[7:0];
  assign tick     = (pre_q == PRE_LAST);
  // Prescaler and tick counter only advance in PLAY/GAP and freeze while paused.
  assign run      = ((state_q == S_PLAY) || (state_q == S_GAP)) && !pause_i;

  // NOTE: every signal driven here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    idx_d   = idx_q;
    note_d  = note_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;

    if (run) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          song_d  = song_sel_i;
          idx_d   = '0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (rom_code == CODE_END) begin
          state_d = S_DONE;
        end else begin
          note_d  = rom_code;
          cnt_d   = (rom_dur == 8'd0) ? 8'd1 : rom_dur;
          pre_d   = '0;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (run && tick) begin
          if (cnt_q == 8'd1) begin
            if (GAP_CNT != 8'd0) begin
              state_d = S_GAP;
              cnt_d   = GAP_CNT;
            end else begin
              state_d = S_NEXT;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      S_GAP: begin
        if (run && tick) begin
          if (cnt_q == 8'd1) state_d = S_NEXT;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      S_NEXT: begin
        // A full song table ends the song rather than wrapping to entry 0.
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        note_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Leaving AUTO mode overrides everything and returns to the reset picture.
    if (!enable_i) begin
      state_d = S_IDLE;
      song_d  = '0;
      idx_d   = '0;
      note_d  = '0;
      pre_d   = '0;
      cnt_d   = '0;
    end
  end

  // NOTE: registered state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      song_q  <= '0;
      idx_q   <= '0;
      note_q  <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      idx_q   <= idx_d;
      note_q  <= note_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rom_addr_o   = {song_q, idx_q};
  assign idx_o        = idx_q;
  assign note_o       = note_q;
  assign note_valid_o = (state_q == S_PLAY) && (note_q != 5'd0) && !pause_i;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE) && enable_i;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a cycle-timeline model built from song entries, tick
// arithmetic and a pause schedule, compared against the DUT every cycle.
module tb_note_sequencer;

  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 1;
  localparam int IDX_W     = 3;
  localparam int N_ENT     = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             enable_i = 1'b0;
  logic             start_i = 1'b0;
  logic             pause_i = 1'b0;
  logic [1:0]       song_sel_i = 2'd0;
  logic [IDX_W+1:0] rom_addr_o;
  logic [12:0]      rom_data_i;
  logic [4:0]       note_o;
  logic             note_valid_o;
  logic             busy_o;
  logic             done_o;
  logic [IDX_W-1:0] idx_o;

  logic [12:0] rom [0:4*N_ENT-1];
  bit          pause_pat [0:1023];
  logic [15:0] exp_q [$];
  int          checks = 0;
  int          failures = 0;
  int          nv_cnt [32];
  int          done_cnt;

  note_sequencer #(
    .TICK_DIV (TICK_DIV),
    .GAP_TICKS(GAP_TICKS),
    .IDX_W    (IDX_W)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .enable_i    (enable_i),
    .start_i     (start_i),
    .pause_i     (pause_i),
    .song_sel_i  (song_sel_i),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data_i),
    .note_o      (note_o),
    .note_valid_o(note_valid_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .idx_o       (idx_o)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) rom_data_i <= rom[rom_addr_o];

  function automatic logic [12:0] ent(input int code, input int dur);
    return {5'(code), 8'(dur)};
  endfunction

  function automatic logic [15:0] observe();
    return {busy_o, note_valid_o, done_o, note_o, rom_addr_o, idx_o};
  endfunction

  function automatic void push(input bit b, input bit v, input bit d, input logic [4:0] n,
                               input logic [1:0] s, input int i);
    exp_q.push_back({b, v, d, n, s, IDX_W'(i), IDX_W'(i)});
  endfunction

  task automatic clear_pause();
    for (int k = 0; k < 1024; k++) pause_pat[k] = 1'b0;
  endtask

  // Expected per-cycle outputs, cycle k being the interval after the k-th edge
  // counted from the edge that accepts start.
  task automatic build_model(input logic [1:0] s);
    logic [4:0]  cur;
    logic [4:0]  code;
    logic [12:0] e;
    int          idx;
    int          rem;
    int          d;
    bit          p;
    bit          fin;
    exp_q.delete();
    cur = 5'd0;
    idx = 0;
    fin = 1'b0;
    while (!fin) begin
      push(1, 0, 0, cur, s, idx);
      push(1, 0, 0, cur, s, idx);
      e    = rom[int'(s) * N_ENT + idx];
      code = e[12:8];
      if (code == 5'h1F) begin
        push(1, 0, 1, cur, s, idx);
        fin = 1'b1;
      end else begin
        cur = code;
        d   = (e[7:0] == 8'd0) ? 1 : int'(e[7:0]);
        rem = d * TICK_DIV;
        while (rem > 0) begin
          p = pause_pat[exp_q.size() + 1];
          push(1, (code != 5'd0) && !p, 0, cur, s, idx);
          if (!p) rem--;
        end
        rem = GAP_TICKS * TICK_DIV;
        while (rem > 0) begin
          p = pause_pat[exp_q.size() + 1];
          push(1, 0, 0, cur, s, idx);
          if (!p) rem--;
        end
        push(1, 0, 0, cur, s, idx);
        if (idx == N_ENT - 1) begin
          push(1, 0, 1, cur, s, idx);
          fin = 1'b1;
        end else begin
          idx++;
        end
      end
    end
    repeat (3) push(0, 0, 0, 5'd0, s, idx);
  endtask

  // noise: 0 quiet, 1 random start/song_sel while busy, 2 start held high while busy.
  task automatic run_song(input logic [1:0] s, input int noise);
    logic [15:0] obs;
    logic [15:0] e;
    build_model(s);
    for (int i = 0; i < 32; i++) nv_cnt[i] = 0;
    done_cnt = 0;
    @(negedge clk);
    song_sel_i = s;
    start_i    = 1'b1;
    pause_i    = pause_pat[0];
    for (int k = 1; k <= exp_q.size(); k++) begin
      e = exp_q[k-1];
      @(posedge clk);
      #1;
      pause_i = pause_pat[k];
      start_i = 1'b0;
      if (e[15]) begin
        if (noise == 1) begin
          start_i    = 1'($urandom_range(0, 1));
          song_sel_i = 2'($urandom);
        end else if (noise == 2) begin
          start_i = 1'b1;
        end
      end
      @(negedge clk);
      obs = observe();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL trace song=%0d cyc=%0d got{busy,nv,done,note,addr,idx}=%h want=%h",
                 s, k, obs, e);
      end
      if (note_valid_o) nv_cnt[note_o]++;
      if (done_o) done_cnt++;
    end
    pause_i    = 1'b0;
    start_i    = 1'b0;
    song_sel_i = 2'd0;
  endtask

  task automatic load_song0();
    rom[0] = ent(5, 2);
    rom[1] = ent(7, 1);
    rom[2] = ent(31, 0);
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      enable_i   = 1'($urandom);
      start_i    = 1'($urandom);
      pause_i    = 1'($urandom);
      song_sel_i = 2'($urandom);
      @(negedge clk);
      obs = observe();
      checks++;
      if (obs !== 16'd0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got=%h want=0000", c, obs);
      end
    end
    enable_i   = 1'b1;
    start_i    = 1'b0;
    pause_i    = 1'b0;
    song_sel_i = 2'd0;
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_song();
    load_song0();
    clear_pause();
    run_song(2'd0, 0);
    checks++;
    if (nv_cnt[5] !== 8) begin
      failures++;
      $display("FAIL song_note5_cycles got=%0d want=8", nv_cnt[5]);
    end
    checks++;
    if (nv_cnt[7] !== 4) begin
      failures++;
      $display("FAIL song_note7_cycles got=%0d want=4", nv_cnt[7]);
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL song_done_pulses got=%0d want=1", done_cnt);
    end
  endtask

  task automatic test_pause();
    load_song0();
    clear_pause();
    for (int k = 6; k <= 15; k++) pause_pat[k] = 1'b1;
    run_song(2'd0, 0);
    checks++;
    if (nv_cnt[5] !== 8) begin
      failures++;
      $display("FAIL pause_note5_cycles got=%0d want=8", nv_cnt[5]);
    end
  endtask

  task automatic test_start_with_pause();
    load_song0();
    clear_pause();
    for (int k = 0; k <= 6; k++) pause_pat[k] = 1'b1;
    run_song(2'd0, 0);
    checks++;
    if (nv_cnt[5] !== 8) begin
      failures++;
      $display("FAIL start_pause_note5_cycles got=%0d want=8", nv_cnt[5]);
    end
  endtask

  task automatic test_enable();
    logic [15:0] obs;
    int busy_seen;
    int done_seen;
    load_song0();
    @(negedge clk);
    song_sel_i = 2'd0;
    start_i    = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (note_valid_o !== 1'b1 || note_o !== 5'd5) begin
      failures++;
      $display("FAIL enable_pre_play got nv=%0b note=%0d want nv=1 note=5", note_valid_o, note_o);
    end
    enable_i  = 1'b0;
    done_seen = int'(done_o);
    @(posedge clk);
    #1;
    obs = observe();
    checks++;
    if (obs !== 16'd0) begin
      failures++;
      $display("FAIL enable_drop_outputs got=%h want=0000", obs);
    end
    busy_seen = 0;
    start_i   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (busy_o) busy_seen++;
      if (done_o) done_seen++;
    end
    checks++;
    if (busy_seen !== 0) begin
      failures++;
      $display("FAIL enable_low_start_busy got=%0d want=0", busy_seen);
    end
    checks++;
    if (done_seen !== 0) begin
      failures++;
      $display("FAIL enable_low_done got=%0d want=0", done_seen);
    end
    start_i  = 1'b0;
    enable_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL enable_restore_idle got busy=%0b want=0", busy_o);
    end
  endtask

  task automatic test_full_table();
    rom[N_ENT] = ent(3, 0);
    for (int i = 1; i < N_ENT; i++) rom[N_ENT + i] = ent($urandom_range(4, 30), $urandom_range(0, 2));
    clear_pause();
    run_song(2'd1, 0);
    checks++;
    if (nv_cnt[3] !== 4) begin
      failures++;
      $display("FAIL zero_dur_cycles got=%0d want=4", nv_cnt[3]);
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL full_table_done got=%0d want=1", done_cnt);
    end
  endtask

  task automatic test_rest();
    rom[2*N_ENT]     = ent(0, 2);
    rom[2*N_ENT + 1] = ent(9, 1);
    rom[2*N_ENT + 2] = ent(31, 0);
    clear_pause();
    run_song(2'd2, 2);
    checks++;
    if (nv_cnt[9] !== 4) begin
      failures++;
      $display("FAIL rest_then_note9 got=%0d want=4", nv_cnt[9]);
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL rest_done got=%0d want=1", done_cnt);
    end
  endtask

  task automatic test_random();
    int code;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < N_ENT; i++) begin
        code = $urandom_range(0, 30);
        if (i > 0 && $urandom_range(0, 5) == 0) code = 31;
        rom[3*N_ENT + i] = ent(code, $urandom_range(0, 3));
      end
      for (int k = 0; k < 1024; k++) pause_pat[k] = (k < 600) && ($urandom_range(0, 7) == 0);
      run_song(2'd3, 1);
      checks++;
      if (done_cnt !== 1) begin
        failures++;
        $display("FAIL random_done it=%0d got=%0d want=1", it, done_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_song();
    logic [15:0] obs;
    int busy_seen;
    load_song0();
    @(negedge clk);
    song_sel_i = 2'd0;
    start_i    = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    obs = observe();
    checks++;
    if (obs !== 16'd0) begin
      failures++;
      $display("FAIL async_reset_outputs got=%h want=0000", obs);
    end
    repeat (2) @(negedge clk);
    rst_ni    = 1'b1;
    busy_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy_o) busy_seen++;
    end
    checks++;
    if (busy_seen !== 0) begin
      failures++;
      $display("FAIL reset_no_resume busy_cycles got=%0d want=0", busy_seen);
    end
  endtask

  initial begin
    for (int i = 0; i < 4*N_ENT; i++) rom[i] = ent(31, 0);
    clear_pause();
    test_reset();
    test_song();
    test_pause();
    test_start_with_pause();
    test_enable();
    test_full_table();
    test_rest();
    test_random();
    test_reset_mid_song();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
